// File: rtl/fetch_ifid.sv
// fetch_ifid: instruction fetch stage plus IF/ID pipeline register.
// Owns the fetch PC and drives a variable-latency instruction memory through a
// request/ready handshake. Hazard stalls are absorbed by a one-entry skid buffer.
// Wrong-path fetches are squashed on decode redirects.
// Optional feature: define FETCH_ALIGN_CHK_EN so that a misaligned redirect sets a sticky err.
module fetch_ifid #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter logic [15:0] NOP      = 16'h0800
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect,
    input  logic [15:0] redirectPC,
    input  logic        haltIn,
    output logic        imemEn,
    output logic [15:0] imemAddr,
    input  logic        imemRdy,
    input  logic [15:0] imemData,
    output logic [15:0] instr,
    output logic [15:0] PC,
    output logic        valid,
    output logic        err
);

    localparam int unsigned XLEN = 16;

`ifdef FETCH_ALIGN_CHK_EN
    localparam bit ALIGN_CHK = 1'b1;
`else
    localparam bit ALIGN_CHK = 1'b0;
`endif

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_DRAIN = 2'd1,
        S_HALT  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [XLEN-1:0]   fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0]   pend_pc_q, pend_pc_d;
    logic              halt_pend_q, halt_pend_d;
    logic [XLEN-1:0]   buf_instr_q, buf_instr_d;
    logic [XLEN-1:0]   buf_pc_q, buf_pc_d;
    logic              buf_valid_q, buf_valid_d;
    logic [XLEN-1:0]   ifid_instr_q, ifid_instr_d;
    logic [XLEN-1:0]   ifid_pc_q, ifid_pc_d;
    logic              ifid_valid_q, ifid_valid_d;
    logic              err_q, err_d;

    logic              rsp_c;
    logic [XLEN-1:0]   fetch_pc_inc_c;
    logic [XLEN-1:0]   target_c;

    // Memory request decoded from registered state; held stable until imemRdy.
    assign imemEn   = ((state_q == S_FETCH) && !buf_valid_q) || (state_q == S_DRAIN);
    assign imemAddr = fetch_pc_q;

    assign rsp_c          = imemEn & imemRdy;
    assign fetch_pc_inc_c = fetch_pc_q + XLEN'(2);
    assign target_c       = {redirectPC[XLEN-1:1], 1'b0};

    assign instr = ifid_instr_q;
    assign PC    = ifid_pc_q;
    assign valid = ifid_valid_q;
    assign err   = err_q;

    // Next-state: halt beats redirect, redirect beats stall; HALT is left only by reset.
    always_comb begin
        state_d      = state_q;
        fetch_pc_d   = fetch_pc_q;
        pend_pc_d    = pend_pc_q;
        halt_pend_d  = halt_pend_q;
        buf_instr_d  = buf_instr_q;
        buf_pc_d     = buf_pc_q;
        buf_valid_d  = buf_valid_q;
        ifid_instr_d = ifid_instr_q;
        ifid_pc_d    = ifid_pc_q;
        ifid_valid_d = ifid_valid_q;
        err_d        = err_q;

        if (state_q == S_HALT) begin
            state_d = S_HALT;
        end else if (haltIn) begin
            ifid_instr_d = NOP;
            ifid_valid_d = 1'b0;
            buf_valid_d  = 1'b0;
            if (imemEn && !imemRdy) begin
                // Let the outstanding request complete before stopping.
                halt_pend_d = 1'b1;
                state_d     = S_DRAIN;
            end else begin
                state_d = S_HALT;
            end
        end else if (redirect && !halt_pend_q) begin
            ifid_instr_d = NOP;
            ifid_valid_d = 1'b0;
            buf_valid_d  = 1'b0;
            if (ALIGN_CHK && redirectPC[0]) begin
                err_d = 1'b1;
            end
            if (rsp_c || !imemEn) begin
                fetch_pc_d = target_c;
                state_d    = S_FETCH;
            end else begin
                pend_pc_d = target_c;
                state_d   = S_DRAIN;
            end
        end else if (state_q == S_DRAIN) begin
            // Wrong-path data is discarded; IF/ID already holds a bubble.
            if (rsp_c) begin
                if (halt_pend_q) begin
                    state_d = S_HALT;
                end else begin
                    fetch_pc_d = pend_pc_q;
                    state_d    = S_FETCH;
                end
            end
        end else begin
            if (buf_valid_q) begin
                if (!stall) begin
                    ifid_instr_d = buf_instr_q;
                    ifid_pc_d    = buf_pc_q;
                    ifid_valid_d = 1'b1;
                    buf_valid_d  = 1'b0;
                end
            end else if (rsp_c) begin
                if (stall) begin
                    buf_instr_d = imemData;
                    buf_pc_d    = fetch_pc_inc_c;
                    buf_valid_d = 1'b1;
                end else begin
                    ifid_instr_d = imemData;
                    ifid_pc_d    = fetch_pc_inc_c;
                    ifid_valid_d = 1'b1;
                end
                fetch_pc_d = fetch_pc_inc_c;
            end else if (!stall) begin
                // No instruction arrived: hand decode a bubble rather than a repeat.
                ifid_instr_d = NOP;
                ifid_valid_d = 1'b0;
            end
        end
    end

    // State and pipeline registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_FETCH;
            fetch_pc_q   <= RESET_PC;
            pend_pc_q    <= '0;
            halt_pend_q  <= 1'b0;
            buf_instr_q  <= '0;
            buf_pc_q     <= '0;
            buf_valid_q  <= 1'b0;
            ifid_instr_q <= NOP;
            ifid_pc_q    <= '0;
            ifid_valid_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            fetch_pc_q   <= fetch_pc_d;
            pend_pc_q    <= pend_pc_d;
            halt_pend_q  <= halt_pend_d;
            buf_instr_q  <= buf_instr_d;
            buf_pc_q     <= buf_pc_d;
            buf_valid_q  <= buf_valid_d;
            ifid_instr_q <= ifid_instr_d;
            ifid_pc_q    <= ifid_pc_d;
            ifid_valid_q <= ifid_valid_d;
            err_q        <= err_d;
        end
    end

endmodule
